mole_scheduler: RTL and testbench
=================================

// Module: mole_scheduler
// PURPOSE
//  Owns the 12-hole mole_up vector for the game FSM. Spawns moles at random free holes, times each
//  mole's up-period, retires moles on hit or timeout, and reports per-cycle hit/escape counts for
//  score and timer logic. Level-dependent pacing; time base is an external 1 ms strobe.
// PARAMETERS
//  NUM_MOLES   12    number of holes (index width 4 bits)
//  MAX_ACTIVE  4     absolute cap on simultaneously raised moles
//  UP_BASE     1500  up-time at level 1, ms
//  UP_STEP     100   up-time reduction per level, ms
//  UP_MIN      400   up-time floor, ms
//  GAP_BASE    800   spawn interval at level 1, ms
//  GAP_STEP    60    spawn-interval reduction per level, ms
//  GAP_MIN     200   spawn-interval floor, ms
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-high
//  enable     in   1   1 = game running and not paused; 0 freezes all timers/FSM
//  clear      in   1   sync pulse: drop all moles, restart gap timer (new game)
//  tick_1ms   in   1   one-cycle strobe every 1 ms
//  level      in   4   game level; 0 treated as 1
//  rand_idx   in   4   random hole index from random_generator, any value 0..15
//  hit        in   12  one-cycle click-on-hole pulses from mouse_monitor
//  mole_up    out  12  registered raised-mole vector
//  hit_cnt    out  4   number of valid hits this cycle (registered, 1-cycle pulse)
//  escape_cnt out  4   number of moles timed out this cycle (registered, 1-cycle pulse)
//  active_cnt out  4   popcount of mole_up
// BEHAVIOUR
//  Reset: mole_up=0, hit_cnt=0, escape_cnt=0, active_cnt=0, all per-mole timers=0, FSM=GAP, gap_cnt=gap_ms.
//  Derived (combinational on level L'=max(level,1)): up_ms=max(UP_BASE-UP_STEP*(L'-1),UP_MIN);
//   gap_ms=max(GAP_BASE-GAP_STEP*(L'-1),GAP_MIN); cap=min(1+L'/2,MAX_ACTIVE). Subtractions done
//   at 16 bits, signed-safe (no underflow wrap); timers 12 bits.
//  Spawn FSM: GAP -> PICK -> PROBE -> GAP.
//   GAP: on enable&tick_1ms, gap_cnt-=1; at gap_cnt==0 and active_cnt<cap go PICK; if at cap, hold
//     gap_cnt at 0 and stay GAP until a slot frees.
//   PICK: idx = (rand_idx>=NUM_MOLES) ? rand_idx-NUM_MOLES : rand_idx; go PROBE.
//   PROBE: if mole_up[idx]==0 and no hit/expire targets idx this cycle: set mole_up[idx], timer[idx]=up_ms,
//     gap_cnt=gap_ms, go GAP. Else idx=(idx+1) mod NUM_MOLES, stay PROBE. At most NUM_MOLES probes; if
//     none free (cap reached by concurrent events), return to GAP with gap_cnt=0.
//  Per-mole: on enable&tick_1ms, each raised mole's timer decrements; reaching 0 clears mole_up[i]
//   and counts one escape.
//  Hit: hit[i]&mole_up[i]&enable -> clear mole_up[i] next edge, counted in hit_cnt. Hit on lowered hole
//   ignored (no count). Hit and expiry same cycle on same mole -> hit wins, no escape.
//  Multiple simultaneous hits/escapes counted in full (popcount). Mole raised in PROBE this cycle is not
//   hittable until the following cycle.
//  Latency: hit pulse -> mole_up bit low and hit_cnt valid on the next rising edge (1 cycle).
//  enable=0: timers, gap_cnt and FSM frozen; hit ignored; mole_up held; hit_cnt/escape_cnt forced 0.
//  clear: highest priority after reset; mole_up=0, timers=0, counts=0, FSM=GAP, gap_cnt=gap_ms;
//   hits in that cycle discarded. Reset mid-operation: immediate return to reset values.
//  level change mid-game affects only subsequently spawned moles/gaps; running timers untouched.
// TESTING
//  level=1, enable=1, 1 ms ticks, rand_idx=5 -> after 800 ticks+2 cycles mole_up=12'h020; after 1500 more
//   ticks bit 5 clears with escape_cnt=1 for one cycle.
//  Mole 5 up, hit[5] pulse -> next edge mole_up[5]=0, hit_cnt=1; hit[7] (mole 7 down) -> hit_cnt=0.
//  rand_idx=14 -> hole 2 chosen; mole 2 already up, rand_idx=2 -> probe lands on hole 3.
//  level=1 cap=1: second spawn blocked while mole up, spawns within 2 cycles after hit frees slot.
//  level=15 -> up_ms=400, gap_ms=200, cap=4; active_cnt never exceeds 4 over 10 s of random stimulus.
//  enable=0 for 500 ticks mid-up -> timer frozen, mole stays up; clear pulse -> mole_up=0, gap restarts.

Source files
------------

// File: rtl/mole_scheduler.sv
// Mole spawn/retire scheduler: owns the raised-mole vector, per-mole up timers and the spawn FSM.
// Pacing (up-time, spawn gap, concurrency cap) derives from the game level on a 1 ms strobe.
module mole_scheduler #(
  parameter int NUM_MOLES  = 12,
  parameter int MAX_ACTIVE = 4,
  parameter int UP_BASE    = 1500,
  parameter int UP_STEP    = 100,
  parameter int UP_MIN     = 400,
  parameter int GAP_BASE   = 800,
  parameter int GAP_STEP   = 60,
  parameter int GAP_MIN    = 200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 tick_1ms,
  input  logic [3:0]           level,
  input  logic [3:0]           rand_idx,
  input  logic [NUM_MOLES-1:0] hit,
  output logic [NUM_MOLES-1:0] mole_up,
  output logic [3:0]           hit_cnt,
  output logic [3:0]           escape_cnt,
  output logic [3:0]           active_cnt
);

  localparam logic [1:0] ST_GAP   = 2'd0;
  localparam logic [1:0] ST_PICK  = 2'd1;
  localparam logic [1:0] ST_PROBE = 2'd2;

  function automatic logic [3:0] popcnt(input logic [NUM_MOLES-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_MOLES; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  logic [3:0]  lvl_eff;
  logic [15:0] lvl_m1;
  logic [15:0] up_dec;
  logic [15:0] gap_dec_lvl;
  logic [11:0] up_ms;
  logic [11:0] gap_ms;
  logic [3:0]  cap_raw;
  logic [3:0]  cap;

  assign lvl_eff     = (level == 4'd0) ? 4'd1 : level;
  assign lvl_m1      = {12'd0, lvl_eff - 4'd1};
  assign up_dec      = 16'(UP_STEP) * lvl_m1;
  assign gap_dec_lvl = 16'(GAP_STEP) * lvl_m1;
  // Compare against base by adding the floor, so the subtraction can never wrap.
  assign up_ms  = 12'((16'(UP_BASE) >= up_dec + 16'(UP_MIN))
                      ? 16'(UP_BASE) - up_dec : 16'(UP_MIN));
  assign gap_ms = 12'((16'(GAP_BASE) >= gap_dec_lvl + 16'(GAP_MIN))
                      ? 16'(GAP_BASE) - gap_dec_lvl : 16'(GAP_MIN));
  assign cap_raw = 4'd1 + {1'b0, lvl_eff[3:1]};
  assign cap     = (cap_raw > 4'(MAX_ACTIVE)) ? 4'(MAX_ACTIVE) : cap_raw;

  logic [1:0]           state, state_nx;
  logic [11:0]          gap_cnt, gap_nx, gap_cur, gap_dec;
  logic                 armed;
  logic [3:0]           idx, idx_nx;
  logic [3:0]           probes, probes_nx;
  logic [11:0]          timer [NUM_MOLES];
  logic [NUM_MOLES-1:0] expire, hit_valid, escape_v, keep, spawn;

  assign active_cnt = popcnt(mole_up);

  always_comb begin
    for (int unsigned i = 0; i < NUM_MOLES; i++)
      expire[i] = enable & tick_1ms & mole_up[i] & (timer[i] <= 12'd1);
  end

  assign hit_valid = hit & mole_up & {NUM_MOLES{enable}};
  assign escape_v  = expire & ~hit_valid;
  assign keep      = mole_up & ~hit_valid & ~expire;

  // The reset value of the gap counter would depend on level; instead an unarmed
  // counter reads as gap_ms until the first enabled cycle latches it.
  assign gap_cur = armed ? gap_cnt : gap_ms;
  assign gap_dec = (tick_1ms && gap_cur != 12'd0) ? gap_cur - 12'd1 : gap_cur;

  always_comb begin
    state_nx  = state;
    gap_nx    = gap_cur;
    idx_nx    = idx;
    probes_nx = probes;
    spawn     = '0;
    case (state)
      ST_GAP: begin
        gap_nx = gap_dec;
        if (gap_dec == 12'd0 && active_cnt < cap) state_nx = ST_PICK;
      end
      ST_PICK: begin
        idx_nx    = (rand_idx >= 4'(NUM_MOLES)) ? rand_idx - 4'(NUM_MOLES) : rand_idx;
        probes_nx = '0;
        state_nx  = ST_PROBE;
      end
      ST_PROBE: begin
        if (!mole_up[idx]) begin
          spawn[idx] = 1'b1;
          gap_nx     = gap_ms;
          state_nx   = ST_GAP;
        end else if (probes == 4'(NUM_MOLES - 1)) begin
          gap_nx   = '0;
          state_nx = ST_GAP;
        end else begin
          idx_nx    = (idx == 4'(NUM_MOLES - 1)) ? 4'd0 : idx + 4'd1;
          probes_nx = probes + 4'd1;
        end
      end
      default: state_nx = ST_GAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mole_up    <= '0;
      hit_cnt    <= '0;
      escape_cnt <= '0;
      state      <= ST_GAP;
      gap_cnt    <= '0;
      armed      <= 1'b0;
      idx        <= '0;
      probes     <= '0;
      for (int unsigned i = 0; i < NUM_MOLES; i++) timer[i] <= '0;
    end else if (clear) begin
      mole_up    <= '0;
      hit_cnt    <= '0;
      escape_cnt <= '0;
      state      <= ST_GAP;
      gap_cnt    <= gap_ms;
      armed      <= 1'b1;
      probes     <= '0;
      for (int unsigned i = 0; i < NUM_MOLES; i++) timer[i] <= '0;
    end else if (enable) begin
      mole_up    <= keep | spawn;
      hit_cnt    <= popcnt(hit_valid);
      escape_cnt <= popcnt(escape_v);
      state      <= state_nx;
      gap_cnt    <= gap_nx;
      armed      <= 1'b1;
      idx        <= idx_nx;
      probes     <= probes_nx;
      for (int unsigned i = 0; i < NUM_MOLES; i++) begin
        if (spawn[i])           timer[i] <= up_ms;
        else if (!keep[i])      timer[i] <= '0;
        else if (tick_1ms)      timer[i] <= timer[i] - 12'd1;
      end
    end else begin
      hit_cnt    <= '0;
      escape_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler: spawn timing, expiry, hits, probing, cap, freeze and clear.
`timescale 1ns/1ps
module tb_mole_scheduler;

  logic        clk = 1'b0;
  logic        reset, enable, clear, tick_1ms;
  logic [3:0]  level, rand_idx;
  logic [11:0] hit;
  logic [11:0] mole_up;
  logic [3:0]  hit_cnt, escape_cnt, active_cnt;

  int total = 0;
  int bad   = 0;

  mole_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .tick_1ms   (tick_1ms),
    .level      (level),
    .rand_idx   (rand_idx),
    .hit        (hit),
    .mole_up    (mole_up),
    .hit_cnt    (hit_cnt),
    .escape_cnt (escape_cnt),
    .active_cnt (active_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One 1 ms strobe followed by an idle cycle; enters and leaves on a falling edge.
  task automatic do_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick_1ms = 1'b1;
      @(negedge clk);
      tick_1ms = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int max_seen;
    int cnt_err;

    reset = 1'b1; enable = 1'b1; clear = 1'b0; tick_1ms = 1'b0;
    level = 4'd1; rand_idx = 4'd5; hit = '0;
    repeat (3) @(negedge clk);
    check("rst_mole_up", 16'(mole_up), 16'h0);
    check("rst_hit_cnt", 16'(hit_cnt), 16'h0);
    check("rst_escape_cnt", 16'(escape_cnt), 16'h0);
    check("rst_active_cnt", 16'(active_cnt), 16'h0);
    reset = 1'b0;
    @(negedge clk);

    // Level 1: gap 800, up 1500, cap 1
    do_ticks(799);
    check("gap_not_elapsed", 16'(mole_up), 16'h0);
    do_ticks(1);
    @(negedge clk);
    check("first_spawn", 16'(mole_up), 16'h020);
    check("first_active", 16'(active_cnt), 16'd1);
    do_ticks(1499);
    check("cap1_blocks", 16'(mole_up), 16'h020);
    tick_1ms = 1'b1;
    @(negedge clk);
    tick_1ms = 1'b0;
    check("expire_clear", 16'(mole_up), 16'h0);
    check("expire_escape", 16'(escape_cnt), 16'd1);
    @(negedge clk);
    check("escape_pulse", 16'(escape_cnt), 16'd0);
    repeat (2) @(negedge clk);
    check("respawn_after_free", 16'(mole_up), 16'h020);

    hit = 12'h080;
    @(negedge clk);
    hit = '0;
    check("hit_lowered_cnt", 16'(hit_cnt), 16'd0);
    check("hit_lowered_mole", 16'(mole_up), 16'h020);
    hit = 12'h020;
    @(negedge clk);
    hit = '0;
    check("hit_clear", 16'(mole_up), 16'h0);
    check("hit_cnt", 16'(hit_cnt), 16'd1);
    check("hit_no_escape", 16'(escape_cnt), 16'd0);
    @(negedge clk);
    check("hit_pulse", 16'(hit_cnt), 16'd0);

    // Level 3: gap 680, up 1300, cap 2
    level = 4'd3; rand_idx = 4'd14;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    do_ticks(680);
    @(negedge clk);
    check("wrap_idx14", 16'(mole_up), 16'h004);
    rand_idx = 4'd2;
    do_ticks(680);
    repeat (2) @(negedge clk);
    check("probe_next", 16'(mole_up), 16'h00C);
    check("two_active", 16'(active_cnt), 16'd2);

    enable = 1'b0;
    hit = 12'h004;
    @(negedge clk);
    hit = '0;
    check("dis_hit_ignored", 16'(hit_cnt), 16'd0);
    do_ticks(500);
    check("dis_frozen", 16'(mole_up), 16'h00C);
    enable = 1'b1;
    do_ticks(619);
    check("timer_resume", 16'(mole_up), 16'h00C);
    tick_1ms = 1'b1;
    @(negedge clk);
    tick_1ms = 1'b0;
    check("expire_after_freeze", 16'(mole_up), 16'h008);
    check("escape_after_freeze", 16'(escape_cnt), 16'd1);

    clear = 1'b1; hit = 12'h008;
    @(negedge clk);
    clear = 1'b0; hit = '0;
    check("clear_mole_up", 16'(mole_up), 16'h0);
    check("clear_hit_discard", 16'(hit_cnt), 16'd0);
    check("clear_active", 16'(active_cnt), 16'd0);
    do_ticks(679);
    check("gap_restart_wait", 16'(mole_up), 16'h0);
    do_ticks(1);
    @(negedge clk);
    check("gap_restart_spawn", 16'(mole_up), 16'h004);

    // Level 15: gap 200, up 400, cap 4
    level = 4'd15; rand_idx = 4'd0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    do_ticks(199);
    check("l15_gap_wait", 16'(active_cnt), 16'd0);
    do_ticks(1);
    @(negedge clk);
    check("l15_spawn", 16'(mole_up), 16'h001);

    max_seen = 0;
    cnt_err = 0;
    for (int c = 0; c < 20000; c++) begin
      tick_1ms = c[0];
      rand_idx = 4'($urandom_range(0, 15));
      hit = ($urandom_range(0, 15) == 0) ? 12'(12'h001 << $urandom_range(0, 11)) : 12'h000;
      @(negedge clk);
      if (int'(active_cnt) > max_seen) max_seen = int'(active_cnt);
      if (int'(active_cnt) != $countones(mole_up)) cnt_err++;
    end
    tick_1ms = 1'b0; hit = '0;
    check("l15_cap_le4", 16'(max_seen <= 4), 16'd1);
    check("l15_overlap", 16'(max_seen >= 2), 16'd1);
    check("l15_active_popcount", 16'(cnt_err), 16'd0);

    reset = 1'b1;
    #2;
    check("async_reset", 16'(mole_up), 16'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
